// File: rtl/trisc_pkg.sv
// Shared arbiter definitions: FSM state constants, owner encoding, counter width.
package trisc_pkg;

  typedef logic [1:0] arb_state_t;

  // state | meaning
  // IDLE  | no grant in the previous cycle
  // CPU   | previous cycle granted the CPU port
  // HOST  | previous cycle granted the host port
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_CPU  = 2'd1;
  localparam arb_state_t ST_HOST = 2'd2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  localparam int CNT_W = 4;

  function automatic owner_e state_owner(input arb_state_t st);
    case (st)
      ST_CPU:  return OWN_CPU;
      ST_HOST: return OWN_HOST;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / host) arbiter in front of a single-port synchronous data RAM.
// Define DMEM_ARB_FAIR_EN to add the host starvation limit; default is pure CPU priority.
module dmem_arbiter
  import trisc_pkg::*;
#(
  parameter int WA         = 7,
  parameter int WD         = 7,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [WA:0] cpu_addr,
  input  logic [WD:0] cpu_wdata,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [WA:0] host_addr,
  input  logic [WD:0] host_wdata,
  output logic        cpu_gnt,
  output logic        host_gnt,
  output logic        cpu_rvalid,
  output logic        host_rvalid,
  output logic [WD:0] cpu_rdata,
  output logic [WD:0] host_rdata,
  output logic [WA:0] mem_addr,
  output logic [WD:0] mem_wdata,
  output logic        mem_we,
  input  logic [WD:0] mem_rdata,
  output logic        cpu_stall
);

  if (STARVE_LIM < 1 || STARVE_LIM > (1 << CNT_W) - 1) begin : g_bad_lim
    $error("dmem_arbiter: STARVE_LIM out of range");
  end

  arb_state_t  state_q, state_d;
  logic        rd_pend_q;
  logic [WA:0] addr_q;
  logic [WD:0] cpu_rdata_q, host_rdata_q;
  logic        host_win;
  owner_e      owner;

`ifdef DMEM_ARB_FAIR_EN
  logic [CNT_W-1:0] starve_cnt_q;

  // At the limit the host takes this cycle even against a CPU request.
  assign host_win = host_req && (!cpu_req || starve_cnt_q == CNT_W'(STARVE_LIM));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else if (host_gnt) begin
      starve_cnt_q <= '0;
    end else if (host_req && starve_cnt_q != '1) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`else
  assign host_win = host_req && !cpu_req;
`endif

  assign host_gnt  = !reset && host_win;
  assign cpu_gnt   = !reset && cpu_req && !host_win;
  assign cpu_stall = cpu_req && !cpu_gnt;

  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = '0;
    mem_we    = 1'b0;
    state_d   = ST_IDLE;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      state_d   = ST_CPU;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
      state_d   = ST_HOST;
    end
  end

  // The state names the previous owner, so it also routes the returning read.
  assign owner       = state_owner(state_q);
  assign cpu_rvalid  = rd_pend_q && owner == OWN_CPU;
  assign host_rvalid = rd_pend_q && owner == OWN_HOST;
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
  assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_pend_q    <= 1'b0;
      addr_q       <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= (cpu_gnt || host_gnt) && !mem_we;
      addr_q    <= mem_addr;
      if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
      if (host_rvalid) host_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized + directed bench for dmem_arbiter with a transaction-level reference model.
// Fairness expectations follow DMEM_ARB_FAIR_EN when the bench is built with it.
module tb_dmem_arbiter;
  import trisc_pkg::*;

  localparam int WA  = 7;
  localparam int WD  = 7;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset;
  logic cpu_req, cpu_we, host_req, host_we;
  logic [WA:0] cpu_addr, host_addr, mem_addr;
  logic [WD:0] cpu_wdata, host_wdata, mem_wdata, mem_rdata;
  logic cpu_gnt, host_gnt, cpu_rvalid, host_rvalid, mem_we, cpu_stall;
  logic [WD:0] cpu_rdata, host_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.WA(WA), .WD(WD), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .cpu_gnt(cpu_gnt), .host_gnt(host_gnt),
    .cpu_rvalid(cpu_rvalid), .host_rvalid(host_rvalid),
    .cpu_rdata(cpu_rdata), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cpu_stall(cpu_stall)
  );

  // Synchronous single-port RAM seen by the arbiter
  logic [WD:0] ram [0:255];
  bit ram_init = 1'b1;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
      ram[16] <= 8'h5A;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: memory contents plus the one outstanding read
  logic [7:0] shadow [0:255];
  bit         m_pend, m_host_owns;
  logic [7:0] m_pval, m_crd, m_hrd, m_last;
  int         m_wait;
  bit         e_cg, e_hg, e_we, e_crv, e_hrv;
  logic [7:0] e_addr, e_wd, e_crd, e_hrd;

  task automatic model_eval();
    bit starve;
    starve = 1'b0;
`ifdef DMEM_ARB_FAIR_EN
    starve = (m_wait == LIM);
`endif
    e_hg   = host_req && (!cpu_req || starve);
    e_cg   = cpu_req && !e_hg;
    e_we   = e_cg ? cpu_we : (e_hg ? host_we : 1'b0);
    e_addr = e_cg ? cpu_addr : (e_hg ? host_addr : m_last);
    e_wd   = e_cg ? cpu_wdata : host_wdata;
    e_crv  = m_pend && !m_host_owns;
    e_hrv  = m_pend && m_host_owns;
    e_crd  = e_crv ? m_pval : m_crd;
    e_hrd  = e_hrv ? m_pval : m_hrd;
  endtask

  task automatic model_commit();
    m_crd = e_crd;
    m_hrd = e_hrd;
    m_pend = (e_cg || e_hg) && !e_we;
    m_host_owns = e_hg;
    if (m_pend) m_pval = shadow[e_addr];
    if (e_we) shadow[e_addr] = e_wd;
    m_last = e_addr;
    if (e_hg) m_wait = 0;
    else if (host_req && m_wait < 15) m_wait++;
  endtask

  task automatic model_reset();
    m_pend = 1'b0; m_host_owns = 1'b0;
    m_crd = '0; m_hrd = '0; m_last = '0; m_wait = 0;
  endtask

  task automatic drive(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                       input bit hr, input bit hw, input logic [7:0] ha, input logic [7:0] hd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ram_init = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 7 + 3);
    shadow[16] = 8'h5A;
    model_reset();
    drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    repeat (3) @(posedge clk);
    ram_init = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_grant: cg=%b hg=%b we=%b addr=%h required 0 0 0 00", cpu_gnt, host_gnt, mem_we, mem_addr);
    end
    checks++;
    if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || cpu_rdata !== 8'h00 || host_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_read: crv=%b hrv=%b crd=%h hrd=%h required 0 0 00 00", cpu_rvalid, host_rvalid, cpu_rdata, host_rdata);
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0 || mem_addr !== 8'h10 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_gnt: cg=%b hg=%b addr=%h we=%b required 1 0 10 0", cpu_gnt, host_gnt, mem_addr, mem_we);
    end
    tick();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A || host_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read_data: crv=%b crd=%h hrv=%b required 1 5a 0", cpu_rvalid, cpu_rdata, host_rvalid);
    end
    checks++;
    if (mem_addr !== 8'h10 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold_addr: addr=%h we=%b required 10 0", mem_addr, mem_we);
    end
    tick();
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL rdata_hold: crv=%b crd=%h required 0 5a", cpu_rvalid, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_collision();
    drive(1, 1, 8'h20, 8'h33, 1, 0, 8'h20, 8'h00);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 8'h33) begin
      errors++;
      $display("FAIL collision_cpu_wins: cg=%b hg=%b we=%b wd=%h required 1 0 1 33", cpu_gnt, host_gnt, mem_we, mem_wdata);
    end
    tick();
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00);
    @(negedge clk);
    checks++;
    if (host_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL collision_retry: hg=%b cg=%b crv=%b required 1 0 0", host_gnt, cpu_gnt, cpu_rvalid);
    end
    tick();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h33) begin
      errors++;
      $display("FAIL collision_data: hrv=%b hrd=%h required 1 33", host_rvalid, host_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    bit         want_host [3];
    want[0] = 8'h53; want[1] = 8'h5A; want[2] = 8'h61;
    want_host[0] = 0; want_host[1] = 1; want_host[2] = 0;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00);
        1: drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h31, 8'h00);
        2: drive(1, 0, 8'h32, 8'h00, 0, 0, 8'h00, 8'h00);
        default: drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      endcase
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (cpu_gnt !== !want_host[c] || host_gnt !== want_host[c]) begin
          errors++;
          $display("FAIL alt_gnt[%0d]: cg=%b hg=%b required %b %b", c, cpu_gnt, host_gnt, !want_host[c], want_host[c]);
        end
      end
      if (c > 0) begin
        checks++;
        if (cpu_rvalid !== !want_host[c-1] || host_rvalid !== want_host[c-1] ||
            (want_host[c-1] ? host_rdata : cpu_rdata) !== want[c-1]) begin
          errors++;
          $display("FAIL alt_rvalid[%0d]: crv=%b hrv=%b crd=%h hrd=%h required owner_host=%b data=%h",
                   c, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata, want_host[c-1], want[c-1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    bit want;
    for (int c = 1; c <= 20; c++) begin
      drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
      @(negedge clk);
`ifdef DMEM_ARB_FAIR_EN
      want = (c % (LIM + 1)) == 0;
`else
      want = 1'b0;
`endif
      checks++;
      if (host_gnt !== want || cpu_stall !== want || cpu_gnt !== !want) begin
        errors++;
        $display("FAIL starve_cycle%0d: hg=%b stall=%b cg=%b required %b %b %b", c, host_gnt, cpu_stall, cpu_gnt, want, want, !want);
      end
      tick();
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive(1, 0, 8'h31, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midreset_gnt: cg=%b required 1", cpu_gnt);
    end
    tick();
    reset = 1'b1;
    model_reset();
    drive(1, 1, 8'h44, 8'h99, 1, 1, 8'h55, 8'h77);
    #1;
    checks++;
    if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || host_gnt !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== 8'h00 || cpu_rdata !== 8'h00 || host_rdata !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: crv=%b hrv=%b cg=%b hg=%b we=%b addr=%h crd=%h hrd=%h required all 0",
               cpu_rvalid, host_rvalid, cpu_gnt, host_gnt, mem_we, mem_addr, cpu_rdata, host_rdata);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL midreset_state: state=%0d required %0d", dut.state_q, ST_IDLE);
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      checks++;
      if (cpu_rvalid !== 1'b0 || host_rvalid !== 1'b0 || cpu_rdata !== 8'h00) begin
        errors++;
        $display("FAIL post_reset_rvalid[%0d]: crv=%b hrv=%b crd=%h required 0 0 00", c, cpu_rvalid, host_rvalid, cpu_rdata);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit cr, cw, hr, hw;
    logic [7:0] ca, cd, ha, hd;
    bit c_stalled = 0, h_stalled = 0;
    cr = 0; cw = 0; hr = 0; hw = 0; ca = 0; cd = 0; ha = 0; hd = 0;
    for (int n = 0; n < 300; n++) begin
      // A stalled requester keeps its request unchanged until granted
      if (!c_stalled) begin
        cr = ($urandom_range(0, 3) != 0); cw = $urandom_range(0, 1);
        ca = 8'($urandom_range(0, 7)); cd = 8'($urandom);
      end
      if (!h_stalled) begin
        hr = $urandom_range(0, 1); hw = $urandom_range(0, 1);
        ha = 8'($urandom_range(0, 7)); hd = 8'($urandom);
      end
      drive(cr, cw, ca, cd, hr, hw, ha, hd);
      @(negedge clk);
      checks++;
      if (cpu_gnt !== e_cg || host_gnt !== e_hg || cpu_stall !== (cr && !e_cg)) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: cg=%b hg=%b stall=%b required %b %b %b", n, cpu_gnt, host_gnt, cpu_stall, e_cg, e_hg, cr && !e_cg);
      end
      checks++;
      if (mem_we !== e_we || mem_addr !== e_addr || (e_we && mem_wdata !== e_wd)) begin
        errors++;
        $display("FAIL rand_mem[%0d]: we=%b addr=%h wd=%h required %b %h %h", n, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd);
      end
      checks++;
      if (cpu_rvalid !== e_crv || host_rvalid !== e_hrv || cpu_rdata !== e_crd || host_rdata !== e_hrd) begin
        errors++;
        $display("FAIL rand_read[%0d]: crv=%b hrv=%b crd=%h hrd=%h required %b %b %h %h",
                 n, cpu_rvalid, host_rvalid, cpu_rdata, host_rdata, e_crv, e_hrv, e_crd, e_hrd);
      end
      c_stalled = cr && !e_cg;
      h_stalled = hr && !e_hg;
      tick();
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_collision();
    test_back_to_back();
    test_starvation();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
